// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx among N byte producers.
// A one-byte staging register feeds uart_tx; an optional per-requester lock keeps packets contiguous.
module uart_tx_arb #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    input  logic [N-1:0]   req_lock,
    input  logic [8*N-1:0] req_data,
    output logic [N-1:0]   req_ack,
    output logic           tx_data_rdy,
    output logic [7:0]     tx_data,
    input  logic           tx_fetch,
    output logic [IDW-1:0] grant_id,
    output logic           busy
);

    typedef enum logic {EMPTY, FULL} state_t;

    localparam logic [N-1:0] ACK_ONE = {{(N-1){1'b0}}, 1'b1};

    state_t         state, state_nxt;
    logic           lock_q;
    logic           win;
    logic [IDW-1:0] win_id;
    logic [IDW-1:0] cand;
    logic           capture;

    // Scan from the farthest candidate to the nearest so the nearest valid one overrides.
    always_comb begin
        win    = 1'b0;
        win_id = grant_id;
        cand   = grant_id;
        if (lock_q) begin
            win = req_valid[grant_id];
        end else begin
            for (int unsigned i = N; i >= 1; i--) begin
                cand = IDW'((32'(grant_id) + i) % N);
                if (req_valid[cand]) begin
                    win    = 1'b1;
                    win_id = cand;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            EMPTY: begin
                if (win) begin
                    state_nxt = FULL;
                    capture   = 1'b1;
                end
            end
            FULL: begin
                if (tx_fetch) state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data  <= '0;
            grant_id <= IDW'(N - 1);
            lock_q   <= 1'b0;
            req_ack  <= '0;
        end else begin
            req_ack <= capture ? (ACK_ONE << win_id) : '0;
            if (capture) begin
                tx_data  <= req_data[8*win_id +: 8];
                grant_id <= win_id;
                lock_q   <= req_lock[win_id];
            end
        end
    end

    assign tx_data_rdy = (state == FULL);
    assign busy        = (state == FULL) | lock_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: behavioural uart_tx stand-in, transaction-level
// reference model, and one task per scenario.
module tb_uart_tx_arb;
    localparam int N   = 4;
    localparam int IDW = $clog2(N);

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_lock  = '0;
    logic [8*N-1:0] req_data  = '0;
    logic [N-1:0]   req_ack;
    logic           tx_data_rdy;
    logic [7:0]     tx_data;
    logic           tx_fetch;
    logic [IDW-1:0] grant_id;
    logic           busy;

    int errors = 0;
    int checks = 0;
    int diffs  = 0;

    always #5 clk = ~clk;

    uart_tx_arb #(.N(N)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_lock(req_lock),
        .req_data(req_data), .req_ack(req_ack), .tx_data_rdy(tx_data_rdy),
        .tx_data(tx_data), .tx_fetch(tx_fetch), .grant_id(grant_id), .busy(busy)
    );

    // uart_tx stand-in: one clk per bit, fetches during its stop bit or when idle.
    logic       u_en = 1'b0, spur = 1'b0, fetch_r = 1'b0, line = 1'b1;
    int         u_rem = 0;
    logic [9:0] u_sh = '1;
    longint     cyc = 0;
    logic [7:0] fetched_q[$];
    longint     fetch_t[$];
    int         ack_log[$];

    assign tx_fetch = fetch_r | spur;

    always @(negedge clk) fetch_r = u_en && tx_data_rdy && (u_rem <= 1);

    // Reference model: staging slot, last grant, lock flag, queue of bytes awaiting fetch.
    logic       m_full = 1'b0, m_lock = 1'b0;
    int         m_last = N - 1;
    int         m_w;
    logic [N-1:0] m_ack = '0;
    logic [7:0] m_data = '0;
    logic [7:0] m_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_full = 1'b0; m_last = N - 1; m_lock = 1'b0; m_ack = '0; m_data = '0;
            m_q.delete();
        end else begin
            m_w   = -1;
            m_ack = '0;
            if (m_full) begin
                if (tx_fetch) m_full = 1'b0;
            end else if (m_lock) begin
                if (req_valid[m_last]) m_w = m_last;
            end else begin
                for (int k = 1; k <= N; k++)
                    if (m_w < 0 && req_valid[(m_last + k) % N]) m_w = (m_last + k) % N;
            end
            if (m_w >= 0) begin
                m_full = 1'b1; m_last = m_w; m_lock = req_lock[m_w];
                m_data = req_data[8*m_w +: 8]; m_ack[m_w] = 1'b1;
                m_q.push_back(m_data);
            end
        end
    end

    always @(posedge clk) begin
        cyc++;
        if (u_rem > 0) begin line = u_sh[0]; u_sh = u_sh >> 1; u_rem--; end
        else line = 1'b1;
        if (tx_fetch && tx_data_rdy) begin
            if (m_q.size() == 0 || m_q[0] !== tx_data) begin
                diffs++;
                $display("model diff: fetched %h, model queue size %0d", tx_data, m_q.size());
            end
            if (m_q.size() != 0) void'(m_q.pop_front());
            u_sh = {1'b1, tx_data, 1'b0}; u_rem = 10;
            fetched_q.push_back(tx_data); fetch_t.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        if ({tx_data_rdy, tx_data, req_ack, grant_id, busy} !==
            {m_full, m_data, m_ack, IDW'(m_last), m_full | m_lock} || $countones(req_ack) > 1) begin
            diffs++;
            $display("model diff t=%0t: rdy=%b data=%h ack=%b gid=%0d busy=%b model %b %h %b %0d %b",
                     $time, tx_data_rdy, tx_data, req_ack, grant_id, busy,
                     m_full, m_data, m_ack, m_last, m_full | m_lock);
        end
        for (int i = 0; i < N; i++) if (req_ack[i]) ack_log.push_back(i);
    end

    task automatic test_reset;
        rst = 1'b1; u_en = 1'b0; req_valid = '0; req_lock = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (tx_data_rdy !== 1'b0 || tx_data !== 8'h00 || req_ack !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b data=%h ack=%b busy=%b, required 0 00 0000 0",
                     tx_data_rdy, tx_data, req_ack, busy);
        end
        checks++;
        if (grant_id !== IDW'(N - 1)) begin
            errors++; $display("FAIL reset_grant: grant_id=%0d, required %0d", grant_id, N - 1);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (diffs !== 0) begin errors++; $display("FAIL reset_model: diffs=%0d, required 0", diffs); end
        diffs = 0;
    endtask

    task automatic test_single;
        fetched_q.delete(); ack_log.delete();
        req_data[7:0] = 8'h55; req_valid = 4'b0001; u_en = 1'b1;
        for (int k = 0; k < 20 && req_ack === '0; k++) @(negedge clk);
        checks++;
        if (req_ack !== 4'b0001) begin errors++; $display("FAIL single_ack: ack=%b, required 0001", req_ack); end
        checks++;
        if (tx_data_rdy !== 1'b1 || tx_data !== 8'h55 || grant_id !== 0) begin
            errors++;
            $display("FAIL single_stage: rdy=%b data=%h gid=%0d, required 1 55 0", tx_data_rdy, tx_data, grant_id);
        end
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (req_ack !== '0) begin errors++; $display("FAIL single_ack_width: ack=%b, required 0000", req_ack); end
        for (int k = 0; k < 20 && fetched_q.size() == 0; k++) @(negedge clk);
        checks++;
        if (fetched_q.size() != 1 || fetched_q[0] !== 8'h55) begin
            errors++; $display("FAIL single_fetch: fetched count=%0d, required one byte 55", fetched_q.size());
        end
        checks++;
        if (tx_data_rdy !== 1'b0) begin errors++; $display("FAIL single_drop: rdy=%b, required 0", tx_data_rdy); end
        repeat (12) @(negedge clk);
        checks++;
        if (diffs !== 0) begin errors++; $display("FAIL single_model: diffs=%0d, required 0", diffs); end
        diffs = 0;
    endtask

    task automatic test_round_robin;
        fetched_q.delete(); fetch_t.delete(); ack_log.delete();
        for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'hA0 + 8'(i);
        req_lock = '0; req_valid = '1;
        repeat (80) @(negedge clk);
        req_valid = '0;
        repeat (15) @(negedge clk);
        checks++;
        if (ack_log.size() < 6 || ack_log.size() != fetched_q.size()) begin
            errors++;
            $display("FAIL rr_counts: acks=%0d fetches=%0d, required equal and >=6", ack_log.size(), fetched_q.size());
        end
        // Previous grant was requester 0, so the rotation starts at 1.
        for (int j = 0; j < ack_log.size() && j < fetched_q.size(); j++) begin
            checks++;
            if (ack_log[j] !== (1 + j) % N || fetched_q[j] !== 8'hA0 + 8'((1 + j) % N)) begin
                errors++;
                $display("FAIL rr_order[%0d]: id=%0d byte=%h, required id=%0d byte=%h",
                         j, ack_log[j], fetched_q[j], (1 + j) % N, 8'hA0 + 8'((1 + j) % N));
            end
        end
        for (int j = 1; j < fetch_t.size(); j++) begin
            checks++;
            if (fetch_t[j] - fetch_t[j-1] !== 10) begin
                errors++; $display("FAIL rr_gap[%0d]: spacing=%0d, required 10", j, fetch_t[j] - fetch_t[j-1]);
            end
        end
        checks++;
        if (diffs !== 0) begin errors++; $display("FAIL rr_model: diffs=%0d, required 0", diffs); end
        diffs = 0;
    endtask

    task automatic test_lock;
        int n2 = 0;
        int p  = -1;
        fetched_q.delete(); ack_log.delete();
        for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'hC0 + 8'(i);
        req_data[23:16] = 8'hB0; req_lock = 4'b0100; req_valid = '1;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (req_ack[2]) begin
                n2++;
                req_data[23:16] = 8'hB0 + 8'(n2);
                req_lock[2]     = (n2 < 2);
            end
        end
        req_valid = '0; req_lock = '0;
        repeat (15) @(negedge clk);
        for (int j = 0; j < ack_log.size(); j++) if (p < 0 && ack_log[j] == 2) p = j;
        checks++;
        if (p < 0 || p + 3 >= ack_log.size() || p + 2 >= fetched_q.size()) begin
            errors++; $display("FAIL lock_seen: first owner index=%0d acks=%0d, required room for 4", p, ack_log.size());
        end else begin
            checks++;
            if (ack_log[p+1] !== 2 || ack_log[p+2] !== 2 || ack_log[p+3] !== 3) begin
                errors++;
                $display("FAIL lock_order: ids=%0d,%0d,%0d, required 2,2,3", ack_log[p+1], ack_log[p+2], ack_log[p+3]);
            end
            checks++;
            if (fetched_q[p] !== 8'hB0 || fetched_q[p+1] !== 8'hB1 || fetched_q[p+2] !== 8'hB2) begin
                errors++;
                $display("FAIL lock_bytes: %h %h %h, required b0 b1 b2", fetched_q[p], fetched_q[p+1], fetched_q[p+2]);
            end
        end
        checks++;
        if (diffs !== 0) begin errors++; $display("FAIL lock_model: diffs=%0d, required 0", diffs); end
        diffs = 0;
    endtask

    task automatic test_lock_idle;
        int busy_low = 0;
        int line_low = 0;
        req_data[15:8] = 8'h3C; req_lock = 4'b0010; req_valid = 4'b0010;
        for (int k = 0; k < 20 && req_ack === '0; k++) @(negedge clk);
        checks++;
        if (req_ack !== 4'b0010) begin errors++; $display("FAIL idle_first_ack: ack=%b, required 0010", req_ack); end
        req_valid = 4'b0001;
        @(negedge clk);
        ack_log.delete();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_low++;
            if (c >= 12 && line !== 1'b1) line_low++;
        end
        checks++;
        if (ack_log.size() != 0) begin errors++; $display("FAIL idle_no_capture: acks=%0d, required 0", ack_log.size()); end
        checks++;
        if (busy_low != 0 || line_low != 0) begin
            errors++; $display("FAIL idle_busy_line: busy low=%0d line low=%0d, required 0 0", busy_low, line_low);
        end
        req_data[15:8] = 8'h3D; req_lock = 4'b0000; req_valid = 4'b0011;
        for (int k = 0; k < 20 && req_ack === '0; k++) @(negedge clk);
        checks++;
        if (req_ack !== 4'b0010 || tx_data !== 8'h3D) begin
            errors++; $display("FAIL idle_resume: ack=%b data=%h, required 0010 3d", req_ack, tx_data);
        end
        req_valid = 4'b0001;
        @(negedge clk);
        for (int k = 0; k < 30 && req_ack === '0; k++) @(negedge clk);
        checks++;
        if (req_ack !== 4'b0001) begin errors++; $display("FAIL idle_release: ack=%b, required 0001", req_ack); end
        req_valid = '0;
        repeat (15) @(negedge clk);
        checks++;
        if (diffs !== 0) begin errors++; $display("FAIL idle_model: diffs=%0d, required 0", diffs); end
        diffs = 0;
    endtask

    task automatic test_reset_mid;
        u_en = 1'b0; req_data[31:24] = 8'h77; req_valid = 4'b1000;
        for (int k = 0; k < 20 && req_ack === '0; k++) @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (tx_data_rdy !== 1'b1 || tx_data !== 8'h77) begin
            errors++; $display("FAIL midrst_staged: rdy=%b data=%h, required 1 77", tx_data_rdy, tx_data);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (tx_data_rdy !== 1'b0 || busy !== 1'b0 || grant_id !== IDW'(N - 1)) begin
            errors++;
            $display("FAIL midrst_async: rdy=%b busy=%b gid=%0d, required 0 0 %0d", tx_data_rdy, busy, grant_id, N - 1);
        end
        @(negedge clk);
        rst = 1'b0; fetched_q.delete();
        req_data[23:16] = 8'h99; req_valid = 4'b0100; u_en = 1'b1;
        for (int k = 0; k < 20 && req_ack === '0; k++) @(negedge clk);
        checks++;
        if (req_ack !== 4'b0100 || tx_data !== 8'h99) begin
            errors++; $display("FAIL midrst_regrant: ack=%b data=%h, required 0100 99", req_ack, tx_data);
        end
        req_valid = '0;
        repeat (15) @(negedge clk);
        checks++;
        if (fetched_q.size() != 1 || fetched_q[0] !== 8'h99) begin
            errors++; $display("FAIL midrst_discard: fetched count=%0d, required one byte 99", fetched_q.size());
        end
        checks++;
        if (diffs !== 0) begin errors++; $display("FAIL midrst_model: diffs=%0d, required 0", diffs); end
        diffs = 0;
    endtask

    task automatic test_spurious;
        u_en = 1'b0; ack_log.delete();
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ack_log.size() != 0 || tx_data_rdy !== 1'b0 || grant_id !== 2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL spur_ignored: acks=%0d rdy=%b gid=%0d busy=%b, required 0 0 2 0",
                     ack_log.size(), tx_data_rdy, grant_id, busy);
        end
        fetched_q.delete();
        req_data[31:24] = 8'h81; req_valid = 4'b1000; u_en = 1'b1;
        for (int k = 0; k < 20 && req_ack === '0; k++) @(negedge clk);
        checks++;
        if (req_ack !== 4'b1000) begin errors++; $display("FAIL spur_next_ack: ack=%b, required 1000", req_ack); end
        req_valid = '0;
        repeat (15) @(negedge clk);
        checks++;
        if (fetched_q.size() != 1 || fetched_q[0] !== 8'h81) begin
            errors++; $display("FAIL spur_next_fetch: fetched count=%0d, required one byte 81", fetched_q.size());
        end
        checks++;
        if (diffs !== 0) begin errors++; $display("FAIL spur_model: diffs=%0d, required 0", diffs); end
        diffs = 0;
    endtask

    task automatic test_random;
        fetched_q.delete(); ack_log.delete();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            req_valid = N'($urandom_range(0, (1 << N) - 1));
            req_lock  = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'($urandom);
        end
        req_valid = '0; req_lock = '0;
        repeat (15) @(negedge clk);
        checks++;
        if (ack_log.size() == 0 || ack_log.size() < fetched_q.size()) begin
            errors++; $display("FAIL random_traffic: acks=%0d fetches=%0d, required nonzero acks >= fetches",
                               ack_log.size(), fetched_q.size());
        end
        checks++;
        if (diffs !== 0) begin errors++; $display("FAIL random_model: diffs=%0d, required 0", diffs); end
        diffs = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_lock_idle();
        test_reset_mid();
        test_spurious();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
